snake_tick_scheduler: RTL and testbench

//  Sequences the combinational next-state function of the game. Divides clk into a score-dependent move tick,

---
 rtl/snake_tick_scheduler.sv | 165 ++++++++++++++++
 tb/tb_snake_tick_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_tick_scheduler.sv
// Move-tick scheduler for the snake game. It divides clk into a score-dependent
// move tick, latches button edges into a 2-bit control code between ticks, and
// pulses commit for one cycle so the game-state registers load the next state.
// It also produces in-range apple coordinates from a free-running Galois LFSR.
module snake_tick_scheduler #(
  parameter int          CNT_W      = 24,
  parameter int          TICK_BASE  = 5_000_000,
  parameter int          TICK_MIN   = 1_000_000,
  parameter int          SPEED_STEP = 40_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       pause,
  input  logic [1:0] cstate,
  input  logic [8:0] cscore,
  output logic [1:0] control,
  output logic       commit,
  output logic [5:0] random_x,
  output logic [5:0] random_y
);

  localparam int             PW      = CNT_W + 9;
  localparam logic [PW-1:0]  BASE_W  = PW'(TICK_BASE);
  localparam logic [PW-1:0]  MIN_W   = PW'(TICK_MIN);
  localparam logic [PW-1:0]  STEP_W  = PW'(SPEED_STEP);
  localparam logic [1:0]     GS_RUN  = 2'd1;
  localparam logic [15:0]    TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             commit_n;
  logic             start_p, start_n;
  logic [1:0]       turn_p, turn_n;
  logic             btn_start_q, btn_right_q, btn_left_q;
  logic             rise_start, rise_right, rise_left;
  logic [1:0]       turn_req;
  logic [15:0]      lfsr;

  // Reload value (period - 1). The product is kept wide so a large score
  // cannot wrap; anything at or below the floor saturates to TICK_MIN.
  function automatic logic [CNT_W-1:0] reload_value(input logic [8:0] score);
    logic [PW-1:0] prod;
    logic [PW-1:0] period;
    prod = STEP_W * PW'(score);
    if (prod >= BASE_W) begin
      period = MIN_W;
    end else begin
      period = BASE_W - prod;
      if (period < MIN_W) period = MIN_W;
    end
    return CNT_W'(period - PW'(1));
  endfunction

  assign rise_start = btn_start & ~btn_start_q;
  assign rise_right = btn_right & ~btn_right_q;
  assign rise_left  = btn_left  & ~btn_left_q;
  // Simultaneous left/right rises cancel each other out.
  assign turn_req   = (rise_right & ~rise_left) ? 2'b01 :
                      (rise_left & ~rise_right) ? 2'b10 : 2'b00;

  // State, counter, commit strobe and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_WAIT;
      count       <= '0;
      commit      <= 1'b0;
      start_p     <= 1'b0;
      turn_p      <= 2'b00;
      btn_start_q <= 1'b0;
      btn_right_q <= 1'b0;
      btn_left_q  <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      commit      <= commit_n;
      start_p     <= start_n;
      turn_p      <= turn_n;
      btn_start_q <= btn_start;
      btn_right_q <= btn_right;
      btn_left_q  <= btn_left;
    end
  end

  // Next-state logic: tick countdown, commit issue and flag bookkeeping.
  always_comb begin
    state_n  = state;
    count_n  = count;
    commit_n = 1'b0;
    start_n  = start_p;
    turn_n   = turn_p;
    // Flags consumed by a commit clear first; a rise on that same edge
    // survives for the next tick.
    if (commit) begin
      start_n = 1'b0;
      turn_n  = 2'b00;
    end
    if (rise_start) start_n = 1'b1;
    case (state)
      S_WAIT: begin
        turn_n = 2'b00;
        if (cstate == GS_RUN) begin
          state_n = S_RUN;
          count_n = reload_value(cscore);
          start_n = 1'b0;
        end else if (start_p && !commit) begin
          commit_n = 1'b1;
        end
      end
      S_RUN, S_PAUSED: begin
        if (cstate != GS_RUN) begin
          state_n = S_WAIT;
          turn_n  = 2'b00;
        end else if (pause) begin
          state_n = S_PAUSED;
        end else begin
          state_n = S_RUN;
          if (turn_n == 2'b00) turn_n = turn_req;
          if (count == '0) begin
            commit_n = 1'b1;
            count_n  = reload_value(cscore);
          end else begin
            count_n  = count - CNT_W'(1);
          end
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  // Control code presented to the next-state function.
  always_comb begin
    control = 2'b11;
    if (cstate != GS_RUN) begin
      if (start_p) control = 2'b00;
    end else if (turn_p != 2'b00) begin
      control = turn_p;
    end
  end

  // Free-running LFSR; coordinates only take values inside the play field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      random_x <= 6'd10;
      random_y <= 6'd10;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
      if (lfsr[5:0] >= 6'd1 && lfsr[5:0] <= 6'd61)
        random_x <= lfsr[5:0];
      if (lfsr[13:8] >= 6'd1 && lfsr[13:8] <= 6'd46)
        random_y <= lfsr[13:8];
    end
  end

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Bench for snake_tick_scheduler: directed phases plus a long randomized run,
// all checked cycle by cycle against an event-level model of the scheduler.
module tb_snake_tick_scheduler;

  localparam int TB_BASE = 20;
  localparam int TB_MIN  = 4;
  localparam int TB_STEP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_right = 1'b0, btn_left = 1'b0, pause = 1'b0;
  logic [1:0] cstate = 2'd0;
  logic [8:0] cscore = 9'd0;
  logic [1:0] control;
  logic       commit;
  logic [5:0] random_x, random_y;

  int  n_chk = 0, n_fail = 0;
  int  cyc = 0;
  bit  chk_en = 0;
  int  n_commits = 0, last_cc = 0, commit_intv = 0;
  bit  prev_commit = 0;
  int  xchg = 0, ychg = 0;
  logic [5:0] prev_x = 6'd10, prev_y = 6'd10;

  // Model state: scheduler modelled as "active or not" plus the absolute
  // cycle at which the next tick is due.
  bit          m_active = 0, m_commit = 0, m_start = 0;
  logic [1:0]  m_turn = 2'b00;
  int          m_cyc = 0, m_due = 0;
  bit          m_qs = 0, m_qr = 0, m_ql = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [5:0]  m_x = 6'd10, m_y = 6'd10;

  always #5 clk = ~clk;

  snake_tick_scheduler #(
    .CNT_W(24), .TICK_BASE(TB_BASE), .TICK_MIN(TB_MIN),
    .SPEED_STEP(TB_STEP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_right(btn_right),
    .btn_left(btn_left), .pause(pause), .cstate(cstate), .cscore(cscore),
    .control(control), .commit(commit), .random_x(random_x), .random_y(random_y)
  );

  function automatic int period_of(input int s);
    int p;
    p = TB_BASE - TB_STEP * s;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, advanced on every clock edge and reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_commit = 0; m_start = 0; m_turn = 2'b00;
      m_cyc = 0; m_due = 0; m_qs = 0; m_qr = 0; m_ql = 0;
      m_lfsr = 16'hACE1; m_x = 6'd10; m_y = 6'd10;
    end else begin
      bit rs, rr, rl, nc, s;
      logic [1:0] t;
      m_cyc++;
      rs = btn_start && !m_qs;
      rr = btn_right && !m_qr;
      rl = btn_left  && !m_ql;
      nc = 0;
      s  = m_commit ? 1'b0 : m_start;
      if (rs) s = 1;
      t  = m_commit ? 2'b00 : m_turn;
      if (!m_active) begin
        t = 2'b00;
        if (cstate == 2'd1) begin
          m_active = 1;
          m_due = m_cyc + period_of(int'(cscore));
          s = 0;
        end else if (m_start && !m_commit) begin
          nc = 1;
        end
      end else if (cstate != 2'd1) begin
        m_active = 0;
        t = 2'b00;
      end else if (pause) begin
        m_due++;
      end else begin
        if (t == 2'b00 && rr != rl) t = rr ? 2'b01 : 2'b10;
        if (m_cyc == m_due) begin
          nc = 1;
          m_due = m_cyc + period_of(int'(cscore));
        end
      end
      m_start = s; m_turn = t; m_commit = nc;
      m_qs = btn_start; m_qr = btn_right; m_ql = btn_left;
      if (m_lfsr[5:0] >= 1 && m_lfsr[5:0] <= 61) m_x = m_lfsr[5:0];
      if (m_lfsr[13:8] >= 1 && m_lfsr[13:8] <= 46) m_y = m_lfsr[13:8];
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] ec;
      if (cstate != 2'd1) ec = m_start ? 2'b00 : 2'b11;
      else                ec = (m_turn != 2'b00) ? m_turn : 2'b11;
      chk("commit", int'(commit), int'(m_commit));
      chk("control", int'(control), int'(ec));
      chk("random_x", int'(random_x), int'(m_x));
      chk("random_y", int'(random_y), int'(m_y));
      chk("x_in_range", int'(random_x >= 6'd1 && random_x <= 6'd61), 1);
      chk("y_in_range", int'(random_y >= 6'd1 && random_y <= 6'd46), 1);
      chk("commit_not_back_to_back", int'(prev_commit && commit), 0);
      prev_commit = commit;
      if (commit) begin
        commit_intv = cyc - last_cc;
        last_cc = cyc;
        n_commits++;
      end
      if (rst_n && random_x != prev_x) xchg++;
      if (rst_n && random_y != prev_y) ychg++;
      prev_x = random_x;
      prev_y = random_y;
    end
  end

  task automatic wait_commit(input int limit, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (commit === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no commit within %0d cycles, required one", tag, limit);
    end
    #1;
  endtask

  task automatic pulse(input bit r, input bit l);
    @(posedge clk); #1;
    btn_right = r; btn_left = l;
    @(posedge clk); #1;
    btn_right = 0; btn_left = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t0;
    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    chk("rst_commit", int'(commit), 0);
    chk("rst_control", int'(control), 3);
    chk("rst_random_x", int'(random_x), 10);
    chk("rst_random_y", int'(random_y), 10);
    n0 = n_commits;
    repeat (100) @(posedge clk);
    #1 chk("idle_no_commit", n_commits - n0, 0);

    // Start request: one commit, two edges after first sampled high
    @(posedge clk); #1;
    t0 = cyc;
    n0 = n_commits;
    btn_start = 1;
    wait_commit(10, "start_commit");
    chk("start_latency", last_cc - t0, 2);
    chk("start_control", int'(control), 0);
    repeat (3) @(posedge clk);
    #1 btn_start = 0;
    repeat (5) @(posedge clk);
    #1 chk("start_single_commit", n_commits - n0, 1);
    cstate = 2'd1;
    wait_commit(40, "run_first");
    wait_commit(40, "run_second");
    chk("interval_score0", commit_intv, 20);

    // Score-dependent period, including the clamp
    cscore = 9'd5;
    wait_commit(40, "s5a"); wait_commit(40, "s5b");
    chk("interval_score5", commit_intv, 10);
    cscore = 9'd9;
    wait_commit(40, "s9a"); wait_commit(40, "s9b");
    chk("interval_score9", commit_intv, 4);
    cscore = 9'd300;
    wait_commit(40, "s300a"); wait_commit(40, "s300b");
    chk("interval_score300", commit_intv, 4);
    cscore = 9'd0;
    wait_commit(40, "s0a");

    // Turn requests: first wins, consumed by one commit; simultaneous cancels
    pulse(1, 0);
    repeat (2) @(posedge clk);
    pulse(0, 1);
    wait_commit(40, "turn_a");
    chk("turn_first_wins", int'(control), 1);
    wait_commit(40, "turn_b");
    chk("turn_cleared", int'(control), 3);
    pulse(1, 1);
    wait_commit(40, "turn_c");
    chk("turn_both_ignored", int'(control), 3);

    // Pause mid-tick holds the count and the pending turn
    pulse(1, 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1 pause = 1;
    n0 = n_commits;
    repeat (50) @(posedge clk);
    #1 pause = 0;
    chk("pause_no_commit", n_commits - n0, 0);
    wait_commit(100, "after_pause");
    chk("pause_interval", commit_intv, 70);
    chk("pause_turn_kept", int'(control), 1);

    // Randomized free run
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      btn_start = ($urandom_range(0, 9) == 0);
      btn_right = ($urandom_range(0, 7) == 0);
      btn_left  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      if ($urandom_range(0, 199) == 0) cstate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) cstate = 2'd1;
      if ($urandom_range(0, 149) == 0) cscore = 9'($urandom_range(0, 511));
    end
    chk("x_changes", int'(xchg > 0), 1);
    chk("y_changes", int'(ychg > 0), 1);

    // Reset in the middle of a run
    btn_start = 0; btn_right = 0; btn_left = 0; pause = 0;
    cscore = 9'd0; cstate = 2'd1;
    wait_commit(60, "pre_reset");
    #1 rst_n = 1'b0;
    cstate = 2'd0;
    #1;
    chk("midrun_reset_commit", int'(commit), 0);
    chk("midrun_reset_control", int'(control), 3);
    chk("midrun_reset_x", int'(random_x), 10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = n_commits;
    repeat (100) @(posedge clk);
    #1 chk("post_reset_no_commit", n_commits - n0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
